// File: rtl/id_ex_decode_pipe.sv
// Registered ID/EX control boundary: RV32I(+M) decode, illegal-encoding detection,
// load-use bubble insertion, and downstream stall/flush handling.
module id_ex_decode_pipe #(
    parameter bit ENABLE_M = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      instruction,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_jal,
    output logic             ex_jalr,
    output logic             ex_lui,
    output logic             ex_auipc,
    output logic [4:0]       ex_alu_op,
    output logic [2:0]       ex_funct3,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;
    localparam logic [4:0] ALU_MUL  = 5'd11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic [4:0] alu_op;
        logic       illegal;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    ctrl_t dec;
    logic  uses_rs1;
    logic  uses_rs2;

    // NOTE: every decode output gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  dec.alu_op = ALU_ADD;
                        3'b001:  dec.alu_op = ALU_SLL;
                        3'b010:  dec.alu_op = ALU_SLT;
                        3'b011:  dec.alu_op = ALU_SLTU;
                        3'b100:  dec.alu_op = ALU_XOR;
                        3'b101:  dec.alu_op = ALU_SRL;
                        3'b110:  dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      dec.alu_op  = ALU_SUB;
                    else if (funct3 == 3'b101) dec.alu_op  = ALU_SRA;
                    else                       dec.illegal = 1'b1;
                end else if (funct7 == F7_M && ENABLE_M) begin
                    // MUL..REMU occupy consecutive codes in funct3 order.
                    dec.alu_op = ALU_MUL + {2'b00, funct3};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                uses_rs1      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                case (funct3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b110: dec.alu_op = ALU_OR;
                    3'b111: dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        if (funct7 != F7_BASE) dec.illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     dec.alu_op  = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.alu_op  = ALU_SRA;
                        else                       dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                uses_rs1       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_src    = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec.illegal = 1'b1;
            end
            OP_STORE: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                if (funct3 > 3'b010) dec.illegal = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                dec.branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec.alu_op  = ALU_SUB;
                    3'b100, 3'b101: dec.alu_op  = ALU_SLT;
                    3'b110, 3'b111: dec.alu_op  = ALU_SLTU;
                    default:        dec.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jal       = 1'b1;
            end
            OP_JALR: begin
                uses_rs1      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jalr      = 1'b1;
                if (funct3 != 3'b000) dec.illegal = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.lui       = 1'b1;
                dec.alu_op    = ALU_LUI;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.auipc     = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // An illegal instruction travels down as a harmless ADD that only raises the flag.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    ctrl_t      ex_ctrl;
    logic       load_use;

    assign load_use = if_valid && ex_valid && ex_ctrl.mem_read && (ex_rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

    assign id_stall = !flush && (ex_stall || load_use);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_funct3  <= '0;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_funct3 <= '0;
            ex_rd     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
        end else if (ex_stall) begin
            ex_valid <= ex_valid;
        end else if (load_use) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_funct3 <= '0;
            ex_rd     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (if_valid) begin
            ex_valid  <= 1'b1;
            ex_ctrl   <= dec;
            ex_funct3 <= funct3;
            ex_rd     <= rd;
            ex_rs1    <= rs1;
            ex_rs2    <= rs2;
        end else begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_funct3 <= '0;
            ex_rd     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_jal        = ex_ctrl.jal;
    assign ex_jalr       = ex_ctrl.jalr;
    assign ex_lui        = ex_ctrl.lui;
    assign ex_auipc      = ex_ctrl.auipc;
    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_illegal    = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_decode_pipe.sv
// Scoreboard bench for id_ex_decode_pipe: the driver queues the expected ID/EX entry
// for every edge, a monitor pops and compares it after the edge.
module tb_id_ex_decode_pipe;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] instruction;
    logic        ex_stall;
    logic        flush;

    logic        id_stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic        ex_alu_src, ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc, ex_illegal;
    logic [4:0]  ex_alu_op, ex_rd, ex_rs1, ex_rs2;
    logic [2:0]  ex_funct3;
    logic [15:0] bubble_cnt;

    logic        n_id_stall, n_ex_valid, n_reg_write, n_mem_to_reg, n_mem_read, n_mem_write;
    logic        n_alu_src, n_branch, n_jal, n_jalr, n_lui, n_auipc, n_illegal;
    logic [4:0]  n_alu_op, n_rd, n_rs1, n_rs2;
    logic [2:0]  n_funct3;
    logic [15:0] n_bubble_cnt;

    id_ex_decode_pipe #(.ENABLE_M(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
        .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_lui(ex_lui), .ex_auipc(ex_auipc),
        .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
    );

    id_ex_decode_pipe #(.ENABLE_M(1'b0), .CNT_W(16)) dut_nom (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
        .ex_stall(ex_stall), .flush(flush), .id_stall(n_id_stall), .ex_valid(n_ex_valid),
        .ex_reg_write(n_reg_write), .ex_mem_to_reg(n_mem_to_reg), .ex_mem_read(n_mem_read),
        .ex_mem_write(n_mem_write), .ex_alu_src(n_alu_src), .ex_branch(n_branch),
        .ex_jal(n_jal), .ex_jalr(n_jalr), .ex_lui(n_lui), .ex_auipc(n_auipc),
        .ex_alu_op(n_alu_op), .ex_funct3(n_funct3), .ex_rd(n_rd), .ex_rs1(n_rs1),
        .ex_rs2(n_rs2), .ex_illegal(n_illegal), .bubble_cnt(n_bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control vector order: reg_write mem_to_reg mem_read mem_write alu_src branch jal jalr lui auipc
    typedef struct packed {
        logic        valid;
        logic [9:0]  ctrl;
        logic [4:0]  alu_op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
        logic [15:0] cnt;
    } ent_t;

    localparam logic [9:0] C_R   = 10'b1000000000;
    localparam logic [9:0] C_LD  = 10'b1110100000;
    localparam logic [9:0] C_ST  = 10'b0001100000;
    localparam logic [9:0] C_I   = 10'b1000100000;
    localparam logic [9:0] C_BR  = 10'b0000010000;
    localparam logic [9:0] C_LUI = 10'b1000100010;

    localparam logic [31:0] ADD3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] LW5    = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD6_5 = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] LW0    = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD6_0 = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] MUL3   = 32'h022081B3; // mul  x3,x1,x2
    localparam logic [31:0] DIV3   = 32'h0220C1B3; // div  x3,x1,x2
    localparam logic [31:0] ILL    = 32'hFFFFFFFF;
    localparam logic [31:0] SUB3   = 32'h402081B3; // sub  x3,x1,x2
    localparam logic [31:0] BEQ    = 32'h00208063; // beq  x1,x2,0
    localparam logic [31:0] SRAI3  = 32'h4020D193; // srai x3,x1,2
    localparam logic [31:0] BR_ILL = 32'h0020A063; // branch funct3=010
    localparam logic [31:0] LUI5   = 32'h123452B7; // lui  x5,0x12345
    localparam logic [31:0] SW5    = 32'h0050A023; // sw   x5,0(x1)

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ent_t mk(input logic v, input logic [9:0] c, input logic [4:0] op,
                                input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic ill, input logic [15:0] cnt);
        ent_t e;
        e.valid = v; e.ctrl = c; e.alu_op = op; e.f3 = f3;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.illegal = ill; e.cnt = cnt;
        return e;
    endfunction

    function automatic ent_t clr(input logic [15:0] cnt);
        return mk(1'b0, 10'd0, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, cnt);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [31:0] ins, input logic st,
                        input logic fl, input logic exp_stall, input ent_t e);
        @(negedge clk);
        rst = r; if_valid = iv; instruction = ins; ex_stall = st; flush = fl;
        #1;
        check("id_stall", {63'd0, id_stall}, {63'd0, exp_stall});
        exp_q.push_back(e);
    endtask

    // Monitor: compares the whole ID/EX entry one time unit after each edge.
    initial begin : monitor
        ent_t e;
        ent_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.valid   = ex_valid;
                a.ctrl    = {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
                             ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc};
                a.alu_op  = ex_alu_op;
                a.f3      = ex_funct3;
                a.rd      = ex_rd;
                a.rs1     = ex_rs1;
                a.rs2     = ex_rs2;
                a.illegal = ex_illegal;
                a.cnt     = bubble_cnt;
                check("ex_entry", {13'd0, a}, {13'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; instruction = '0; ex_stall = 1'b0; flush = 1'b0;

        step(1, 0, 32'd0, 0, 0, 0, clr(0));
        step(1, 0, 32'd0, 0, 0, 0, clr(0));
        step(0, 0, 32'd0, 0, 0, 0, clr(0));

        step(0, 1, ADD3, 0, 0, 0, mk(1, C_R, 0, 0, 3, 1, 2, 0, 0));
        @(posedge clk); #2;
        check("nom_add_illegal", {63'd0, n_illegal}, 64'd0);
        check("nom_add_reg_write", {63'd0, n_reg_write}, 64'd1);

        // Load-use through rs1: one bubble, then the held add is captured.
        step(0, 1, LW5,    0, 0, 0, mk(1, C_LD, 0, 2, 5, 1, 0, 0, 0));
        step(0, 1, ADD6_5, 0, 0, 1, clr(1));
        step(0, 1, ADD6_5, 0, 0, 0, mk(1, C_R, 0, 0, 6, 5, 0, 0, 1));
        // Load to x0 never stalls.
        step(0, 1, LW0,    0, 0, 0, mk(1, C_LD, 0, 2, 0, 1, 0, 0, 1));
        step(0, 1, ADD6_0, 0, 0, 0, mk(1, C_R, 0, 0, 6, 0, 0, 0, 1));

        step(0, 1, MUL3, 0, 0, 0, mk(1, C_R, 11, 0, 3, 1, 2, 0, 1));
        @(posedge clk); #2;
        check("nom_mul_illegal", {63'd0, n_illegal}, 64'd1);
        check("nom_mul_reg_write", {63'd0, n_reg_write}, 64'd0);
        check("nom_mul_alu_op", {59'd0, n_alu_op}, 64'd0);

        step(0, 1, DIV3,   0, 0, 0, mk(1, C_R, 15, 4, 3, 1, 2, 0, 1));
        step(0, 1, ILL,    0, 0, 0, mk(1, 10'd0, 0, 7, 31, 31, 31, 1, 1));
        step(0, 1, SUB3,   0, 0, 0, mk(1, C_R, 1, 0, 3, 1, 2, 0, 1));
        step(0, 1, BEQ,    0, 0, 0, mk(1, C_BR, 1, 0, 0, 1, 2, 0, 1));
        step(0, 1, SRAI3,  0, 0, 0, mk(1, C_I, 7, 5, 3, 1, 2, 0, 1));
        step(0, 1, BR_ILL, 0, 0, 0, mk(1, 10'd0, 0, 2, 0, 1, 2, 1, 1));
        step(0, 1, LUI5,   0, 0, 0, mk(1, C_LUI, 10, 5, 5, 8, 3, 0, 1));

        // Downstream stall for three cycles holds the entry; flush overrides stall.
        step(0, 1, ADD3, 0, 0, 0, mk(1, C_R, 0, 0, 3, 1, 2, 0, 1));
        for (int i = 0; i < 3; i++)
            step(0, 1, ADD6_5, 1, 0, 1, mk(1, C_R, 0, 0, 3, 1, 2, 0, 1));
        step(0, 1, ADD6_5, 1, 1, 0, clr(1));

        // Flush during a load-use hazard: no counted bubble, no stall.
        step(0, 1, LW5,    0, 0, 0, mk(1, C_LD, 0, 2, 5, 1, 0, 0, 1));
        step(0, 1, ADD6_5, 0, 1, 0, clr(1));
        step(0, 1, ADD6_5, 0, 0, 0, mk(1, C_R, 0, 0, 6, 5, 0, 0, 1));

        // Load-use through the store data register.
        step(0, 1, LW5, 0, 0, 0, mk(1, C_LD, 0, 2, 5, 1, 0, 0, 1));
        step(0, 1, SW5, 0, 0, 1, clr(2));
        step(0, 1, SW5, 0, 0, 0, mk(1, C_ST, 0, 2, 0, 1, 5, 0, 2));
        step(0, 0, ADD3, 0, 0, 0, clr(2));

        // Reset while stalled clears everything on the next edge.
        step(1, 1, ADD3,  1, 0, 1, clr(0));
        step(1, 0, 32'd0, 0, 0, 0, clr(0));
        step(0, 0, 32'd0, 0, 0, 0, clr(0));

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
